// File: rtl/ddr_tx_sched.sv
// ddr_tx_sched: round-robin two-source scheduler framing words into DDR bit pairs (PRE, SHIFT, GAP).
// Define DDR_TX_PARITY_EN to append an even-parity SHIFT cycle after the data pairs.
module ddr_tx_sched #(
  parameter int WIDTH   = 8,
  parameter int PRE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             d_rise,
  output logic             d_fall,
  output logic             lane_en,
  output logic             busy,
  output logic             grant_id
);
`ifdef DDR_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int HALF = WIDTH / 2;
  localparam int SH   = HALF + PAR;
  localparam int MAXC = (PRE_CYC > SH) ? PRE_CYC : SH;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, PRE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, word;
  logic             last_q, last_d, grant_q, grant_d, par_q, par_d;
  logic             d_rise_q, d_rise_d, d_fall_q, d_fall_d;
  logic             lane_en_q, lane_en_d, busy_q, busy_d;
  logic             win0, win1, par_slot;

  // Output flops are loaded from the next state, so each output cycle matches state_q.
  always_comb begin
    win0       = req0_valid & (~req1_valid | last_q);
    win1       = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state_q == IDLE) & win0;
    req1_ready = (state_q == IDLE) & win1;
    word       = req1_ready ? req1_data : req0_data;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    last_d     = last_q;
    grant_d    = grant_q;
    par_d      = par_q;
    case (state_q)
      IDLE: if (req0_ready | req1_ready) begin
        state_d = PRE;
        cnt_d   = '0;
        sr_d    = word;
        last_d  = req1_ready;
        grant_d = req1_ready;
        par_d   = ^word;
      end
      PRE: begin
        state_d = (cnt_q == CW'(PRE_CYC - 1)) ? SHIFT : PRE;
        cnt_d   = (cnt_q == CW'(PRE_CYC - 1)) ? '0 : cnt_q + CW'(1);
      end
      SHIFT: begin
        state_d = (cnt_q == CW'(SH - 1)) ? GAP : SHIFT;
        cnt_d   = (cnt_q == CW'(SH - 1)) ? '0 : cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (state_d == SHIFT) sr_d = sr_q << 2;
    par_slot  = (state_d == SHIFT) & (cnt_d == CW'(HALF));
    lane_en_d = (state_d == PRE) | (state_d == SHIFT);
    busy_d    = state_d != IDLE;
    d_rise_d  = (state_d == PRE) | ((state_d == SHIFT) & (par_slot ? par_q : sr_q[WIDTH-1]));
    d_fall_d  = (state_d == SHIFT) & (par_slot ? ~par_q : sr_q[WIDTH-2]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      par_q     <= 1'b0;
      d_rise_q  <= 1'b0;
      d_fall_q  <= 1'b0;
      lane_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      par_q     <= par_d;
      d_rise_q  <= d_rise_d;
      d_fall_q  <= d_fall_d;
      lane_en_q <= lane_en_d;
      busy_q    <= busy_d;
    end
  end

  assign d_rise   = d_rise_q;
  assign d_fall   = d_fall_q;
  assign lane_en  = lane_en_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_ddr_tx_sched.sv
// tb_ddr_tx_sched: per-cycle vector table for ddr_tx_sched (WIDTH=8, PRE_CYC=1).
// Expected bundle = {req0_ready, req1_ready, d_rise, d_fall, lane_en, busy, grant_id}.
module tb_ddr_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, d_rise, d_fall, lane_en, busy, grant_id;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [6:0] exp;
    logic       chk;
  } vec_t;

  vec_t vq[$];

  ddr_tx_sched #(.WIDTH(8), .PRE_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .d_rise(d_rise), .d_fall(d_fall), .lane_en(lane_en), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: test did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic p(input logic r, input logic v0, input logic [7:0] d0,
                   input logic v1, input logic [7:0] d1, input logic [6:0] exp, input logic chk);
    vec_t v;
    v.rst = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.exp = exp; v.chk = chk;
    vq.push_back(v);
  endtask

  initial begin
    logic [6:0] act;
    p(0, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 0);
    p(0, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 1);
`ifndef DDR_TX_PARITY_EN
    // single word 0xA5 from req0
    p(1, 1, 8'hA5, 0, 8'h00, 7'b10_00_000, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_01_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_01_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_010, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 1);
    // both valid after reset; data of the idle requester wiggles mid-frame
    p(0, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 1);
    p(1, 1, 8'h3C, 1, 8'hC3, 7'b10_00_000, 1);
    p(1, 1, 8'h3C, 1, 8'h55, 7'b00_10_110, 1);
    p(1, 1, 8'h3C, 1, 8'hAA, 7'b00_00_110, 1);
    p(1, 1, 8'h3C, 1, 8'h0F, 7'b00_11_110, 1);
    p(1, 1, 8'h3C, 1, 8'hF0, 7'b00_11_110, 1);
    p(1, 1, 8'h3C, 1, 8'h12, 7'b00_00_110, 1);
    p(1, 1, 8'h3C, 1, 8'h34, 7'b00_00_010, 1);
    p(1, 1, 8'h3C, 1, 8'hC3, 7'b01_00_000, 1);
    p(1, 1, 8'h00, 1, 8'h66, 7'b00_10_111, 1);
    p(1, 1, 8'hFF, 1, 8'h66, 7'b00_11_111, 1);
    p(1, 1, 8'h5A, 1, 8'h66, 7'b00_00_111, 1);
    p(1, 1, 8'h5A, 1, 8'h66, 7'b00_00_111, 1);
    p(1, 1, 8'h5A, 1, 8'h66, 7'b00_11_111, 1);
    p(1, 1, 8'h5A, 1, 8'h66, 7'b00_00_011, 1);
    p(1, 1, 8'h3C, 1, 8'hC3, 7'b10_00_001, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_11_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_11_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_010, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 1);
    // reset during the second SHIFT cycle of 0xFF, then a tie
    p(1, 0, 8'h00, 1, 8'hFF, 7'b01_00_000, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_111, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_11_111, 1);
    p(0, 0, 8'h00, 0, 8'h00, 7'b00_11_111, 1);
    p(1, 1, 8'h81, 1, 8'hFF, 7'b10_00_000, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_01_110, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_010, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 1);
`else
    // 0x07 with the trailing parity pair (1,0)
    p(1, 1, 8'h07, 0, 8'h00, 7'b10_00_000, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_00_110, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_00_110, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_01_110, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_11_110, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_10_110, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b00_00_010, 1);
    p(1, 1, 8'h07, 0, 8'h00, 7'b10_00_000, 1);
    p(1, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
    p(0, 0, 8'h00, 0, 8'h00, 7'b00_10_110, 1);
`endif
    for (int i = 0; i < 20; i++) p(1, 0, 8'h00, 0, 8'h00, 7'b00_00_000, 1);
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      rst        = vq[i].rst;
      req0_valid = vq[i].v0;
      req0_data  = vq[i].d0;
      req1_valid = vq[i].v1;
      req1_data  = vq[i].d1;
      @(negedge clk);
      if (vq[i].chk) begin
        total++;
        act = {req0_ready, req1_ready, d_rise, d_fall, lane_en, busy, grant_id};
        if (act !== vq[i].exp) begin
          bad++;
          $display("FAIL vec%0d {rdy0,rdy1,rise,fall,lane,busy,gid} got=%b want=%b", i, act, vq[i].exp);
        end
      end
    end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, d_rise, d_fall, lane_en, busy, grant_id} !== 7'b0) begin
      bad++;
      $display("FAIL reset state got=%b", {req0_ready, req1_ready, d_rise, d_fall, lane_en, busy, grant_id});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr_tx_sched.md
Name: ddr_tx_sched

Overview:
Two-requester transmit scheduler for a DDR output lane.
- Round-robin arbitrates between two word sources with valid/ready handshakes.
- Frames the granted word with a preamble and a trailing gap.
- Serializes the word into per-cycle bit pairs: d_rise is launched on the rising edge of clk, d_fall on the falling edge, by the downstream DDR output flops.
- Sits between packet sources and the DDR output flop pair.

Parameters:
- WIDTH, 8, payload bits per word; must be even and ≥2.
- PRE_CYC, 1, preamble cycles per frame; must be ≥1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk; 0 resets.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- d_rise  output  1  bit for the rising-edge DDR flop.
- d_fall  output  1  bit for the falling-edge DDR flop.
- lane_en  output  1  lane driving (preamble, data or parity).
- busy  output  1  frame in progress (any state other than IDLE).
- grant_id  output  1  requester of the current or most recent frame.

Behaviour:
- States: IDLE, PRE, SHIFT, GAP. d_rise, d_fall, lane_en, busy and grant_id are registered.
- Reset (rst=0 at posedge):
  - state=IDLE; d_rise=d_fall=lane_en=busy=0; grant_id=0.
  - Round-robin pointer last=1, so req0 wins the first tie.
  - Shift register and counters cleared.
  - Reset mid-frame aborts the frame immediately; the aborted word is not retransmitted.
- IDLE:
  - Arbiter is combinational from the valids.
  - Only one valid asserted: that requester wins.
  - Both valid: the requester ≠ last wins.
  - reqN_ready is asserted combinationally for the winner only, in IDLE only. The handshake completes in the same cycle; ready is never asserted outside IDLE.
  - On accept: load the word into the shift register, last←winner, grant_id←winner, go to PRE.
  - Outputs during IDLE are all 0.
- PRE: runs for PRE_CYC cycles with lane_en=1, busy=1, d_rise=1, d_fall=0. Then go to SHIFT.
- SHIFT:
  - Runs WIDTH/2 cycles.
  - Each cycle: d_rise=sr[WIDTH-1], d_fall=sr[WIDTH-2], then shift left by 2. The MSB pair goes first.
  - lane_en=1, busy=1.
  - After the last pair, go to GAP.
- GAP: one cycle with lane_en=0, d_rise=d_fall=0, busy=1. Then go to IDLE.
- Latency and throughput:
  - Accept at cycle T; preamble on outputs from T+1.
  - Data cycles T+1+PRE_CYC .. T+PRE_CYC+WIDTH/2.
  - GAP follows the last data cycle; earliest next accept is the cycle after GAP.
  - Frame period = PRE_CYC + WIDTH/2 + 2 cycles (7 at defaults).
- Requester data is not sampled outside the accept cycle. Input changes mid-frame have no effect.
- Valids that drop while not granted are ignored; nothing is queued.
- Counters are sized clog2 of the maximum count plus 1. There is no wrap within a frame.

Optional Feature:
- Macro: DDR_TX_PARITY_EN.
- Defined:
  - One extra SHIFT cycle after the last data pair: d_rise = XOR of the accepted word (even parity), d_fall = its inverse.
  - Frame period becomes PRE_CYC + WIDTH/2 + 3.
- Undefined: no parity cycle; timing exactly as above.

Test Plan (all with WIDTH=8, PRE_CYC=1):
- Reset then single word: rst=0 for 2 cycles then 1; req0_valid=1, data=0xA5 at T.
  - req0_ready=1 at T only.
  - T+1: lane_en=1, (1,0) preamble.
  - T+2..T+5 (d_rise,d_fall) = (1,0),(1,0),(0,1),(0,1).
  - T+6: lane_en=0, busy=1. T+7: busy=0.
- Simultaneous requests after reset: both valid continuously, req0=0x3C, req1=0xC3.
  - req0 accepted at T, req1 at T+7, req0 at T+14.
  - grant_id: 0, 1, 0.
  - Data pairs for 0x3C are (0,0),(1,1),(1,1),(0,0).
- Ready discipline: req1_valid held high during req0's frame.
  - req1_ready=0 in PRE/SHIFT/GAP.
  - req1 accepted exactly in the first IDLE cycle.
  - Changing req1_data during the frame changes nothing on d_rise/d_fall.
- Reset mid-frame: rst=0 at the second SHIFT cycle of 0xFF.
  - Next cycle all outputs 0, state IDLE.
  - After release, a tie grants req0.
- Idle hold: no valids for 20 cycles → lane_en=busy=d_rise=d_fall=0 and both readys 0 throughout.
- Parity (DDR_TX_PARITY_EN defined), data=0x07: after the data pairs, one extra cycle with (d_rise,d_fall)=(1,0); GAP at T+7; next accept at T+8.
